if_stage: RTL and testbench

//   Instruction-fetch stage of the pipelined RV32I core; sits directly upstream of decode.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/if_static_predictor.sv | 22 ++
 rtl/if_stage.sv | 85 ++++++++
 tb/tb_if_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and helpers for the pipeline.
// Provides opcodes, the NOP encoding and the B-type immediate decoder.
package riscv_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        b_imm = {{20{instr[31]}}, instr[7], instr[30:25],
                 instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_static_predictor.sv
// Static backward-taken predictor for conditional branches.
// Pre-decodes the fetched word and yields a predicted target.
module if_static_predictor
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    logic unused_instr_bits;

    assign unused_instr_bits = ^instr[24:12];

    // backward branch when sign bit of the offset is set
    always_comb begin
        pred_taken  = (instr[6:0] == OPC_BRANCH) && instr[31];
        pred_target = pc + b_imm(instr);
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register.
// Optional static branch prediction enabled by IF_STATIC_PREDICT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_pred_taken
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        unused_redirect_lsb;

    assign pc_plus4            = pc + 32'd4;
    assign imem_addr           = pc;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef IF_STATIC_PREDICT_EN
    if_static_predictor u_pred (
        .instr       (imem_rdata),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus4;
`endif

    // next-pc select: redirect beats stall beats prediction
    always_comb begin
        pc_next = pc_plus4;
        if (redirect_valid)
            pc_next = {redirect_pc[31:2], 2'b00};
        else if (stall)
            pc_next = pc;
        else if (pred_taken)
            pc_next = pred_target;
    end

    // pc register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    // IF/ID register: bubble on redirect/flush, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid      <= 1'b0;
            if_id_pc         <= 32'd0;
            if_id_pc_plus4   <= 32'd0;
            if_id_instr      <= NOP_INSTR;
            if_id_pred_taken <= 1'b0;
        end else if (redirect_valid || flush) begin
            if_id_valid      <= 1'b0;
            if_id_instr      <= NOP_INSTR;
            if_id_pred_taken <= 1'b0;
        end else if (!stall) begin
            if_id_valid      <= 1'b1;
            if_id_pc         <= pc;
            if_id_pc_plus4   <= pc_plus4;
            if_id_instr      <= imem_rdata;
            if_id_pred_taken <= pred_taken;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
// Instruction memory returns a non-branch word derived from the address.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_pred_taken;

    logic        ovr_en;
    logic [31:0] ovr_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[24:0], 7'b0110011};
    endfunction

    assign imem_rdata = ovr_en ? ovr_val : mem_word(imem_addr);

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instr      (if_id_instr),
        .if_id_pred_taken (if_id_pred_taken)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_addr got %h want %h", imem_addr, 32'h0);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_valid got %b want 0", if_id_valid);
        end
        n_cmp++;
        if (if_id_instr !== 32'h13) begin
            n_bad++;
            $display("FAIL rst_instr got %h want 13", if_id_instr);
        end
        n_cmp++;
        if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0
            || if_id_pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_fields got %h %h %b want 0 0 0",
                     if_id_pc, if_id_pc_plus4, if_id_pred_taken);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 32'h4) begin
            n_bad++;
            $display("FAIL seq_addr1 got %h want 4", imem_addr);
        end
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0
            || if_id_pc_plus4 !== 32'h4
            || if_id_instr !== 32'h0000_0033) begin
            n_bad++;
            $display("FAIL seq_ifid0 got %b %h %h %h want 1 0 4 33",
                     if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr);
        end
        step();
        n_cmp++;
        if (imem_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL seq_addr2 got %h want 8", imem_addr);
        end
        n_cmp++;
        if (if_id_pc !== 32'h4 || if_id_instr !== 32'h0000_0233) begin
            n_bad++;
            $display("FAIL seq_ifid4 got %h %h want 4 233",
                     if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (imem_addr !== 32'h8 || if_id_pc !== 32'h4
                || if_id_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_hold%0d got %h %h %b want 8 4 1",
                         i, imem_addr, if_id_pc, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (imem_addr !== 32'hC || if_id_pc !== 32'h8
            || if_id_instr !== 32'h0000_0433) begin
            n_bad++;
            $display("FAIL stall_release got %h %h %h want c 8 433",
                     imem_addr, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_redirect_stall();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        stall          = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL redir_addr got %h want 100", imem_addr);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13
            || if_id_pc !== 32'h8) begin
            n_bad++;
            $display("FAIL redir_bubble got %b %h %h want 0 13 8",
                     if_id_valid, if_id_instr, if_id_pc);
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step();
        n_cmp++;
        if (imem_addr !== 32'h104 || if_id_pc !== 32'h100
            || if_id_valid !== 1'b1
            || if_id_instr !== 32'h0000_8033) begin
            n_bad++;
            $display("FAIL redir_next got %h %h %b %h want 104 100 1 8033",
                     imem_addr, if_id_pc, if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_flush();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        flush          = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'h14) begin
            n_bad++;
            $display("FAIL flush_addr got %h want 14", imem_addr);
        end
        n_cmp++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin
            n_bad++;
            $display("FAIL flush_bubble got %b %h want 0 13",
                     if_id_valid, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_addr got %h want fffffffc", imem_addr);
        end
        step();
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC
            || if_id_pc_plus4 !== 32'h0) begin
            n_bad++;
            $display("FAIL wrap_next got %h %h %h want 0 fffffffc 0",
                     imem_addr, if_id_pc, if_id_pc_plus4);
        end
    endtask

    task automatic test_predict();
        logic [31:0] exp_pc;
        logic        exp_pt;
`ifdef IF_STATIC_PREDICT_EN
        exp_pc = 32'h1C;
        exp_pt = 1'b1;
`else
        exp_pc = 32'h24;
        exp_pt = 1'b0;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = 32'hFE00_0EE3;
        step();
        ovr_en = 1'b0;
        n_cmp++;
        if (imem_addr !== exp_pc) begin
            n_bad++;
            $display("FAIL pred_addr got %h want %h", imem_addr, exp_pc);
        end
        n_cmp++;
        if (if_id_pred_taken !== exp_pt || if_id_pc !== 32'h20
            || if_id_instr !== 32'hFE00_0EE3) begin
            n_bad++;
            $display("FAIL pred_ifid got %b %h %h want %b 20 fe000ee3",
                     if_id_pred_taken, if_id_pc, if_id_instr, exp_pt);
        end
    endtask

    task automatic test_mid_reset();
        stall = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_valid !== 1'b0
            || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0
            || if_id_instr !== 32'h13 || if_id_pred_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got %h %b %h %h %h %b want 0 0 0 0 13 0",
                     imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4,
                     if_id_instr, if_id_pred_taken);
        end
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (imem_addr !== 32'h4 || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset got %h %b want 4 1",
                     imem_addr, if_id_valid);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ovr_en         = 1'b0;
        ovr_val        = 32'h0;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_flush();
        test_wrap();
        test_predict();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
